// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter and sequencer for the 64-word data memory.
// Each transaction takes three cycles: IDLE (arbitrate and latch), ACCESS
// (drive the memory pins for one cycle) and RESP (one-cycle ack to the winner).
// Optional feature macro: ARB_ROUND_ROBIN_EN.
//   defined   -> ties go to the port that was not granted last.
//   undefined -> fixed priority: port 0 always wins a tie.
module mem_arbiter #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        err0,
    output logic [31:0] rdata0,
    output logic        ack1,
    output logic        err1,
    output logic [31:0] rdata1,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // First byte address past the end of the memory.
    localparam logic [31:0] END_ADDR = BASE_ADDR + 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Transaction latched in IDLE; held stable through ACCESS and RESP.
    logic        win;        // 0 = port 0, 1 = port 1
    logic        lat_we;
    logic        lat_err;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    // Selected request, decoded combinationally from the winning port.
    logic        grant1;
    logic        sel_we;
    logic        sel_err;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

`ifdef ARB_ROUND_ROBIN_EN
    logic        last_grant; // port granted in the most recent RESP
`endif

    // Pick a winner among active requesters and range/alignment-check its address.
    always_comb begin
        // NOTE: every signal assigned in an always_comb gets a default up front,
        // so no path through the block leaves it unassigned and infers a latch.
        grant1    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        // On a tie, port 1 wins only if port 0 was granted last.
        grant1    = req1 & (~req0 | ~last_grant);
`else
        grant1    = req1 & ~req0;
`endif
        sel_we    = grant1 ? we1    : we0;
        sel_addr  = grant1 ? addr1  : addr0;
        sel_wdata = grant1 ? wdata1 : wdata0;
        sel_err   = (sel_addr < BASE_ADDR) || (sel_addr >= END_ADDR) ||
                    (sel_addr[1:0] != 2'b00);
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        err0      = 1'b0;
        err1      = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) state_nxt = ACCESS;
            end
            ACCESS: begin
                // Pins come only from latched state, never straight from req/addr.
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
                mem_write = ~lat_err & lat_we;
                mem_read  = ~lat_err & ~lat_we;
                state_nxt = RESP;
            end
            RESP: begin
                ack0      = ~win;
                ack1      = win;
                err0      = ~win & lat_err;
                err1      = win & lat_err;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset drops mem_write asynchronously mid-access.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Latch the winning request when a transaction starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win       <= 1'b0;
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
        end else if (state == IDLE && (req0 || req1)) begin
            win       <= grant1;
            lat_we    <= sel_we;
            lat_err   <= sel_err;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
        end
    end

    // Capture read data on the edge closing ACCESS; the loser's rdata holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0 <= 32'd0;
            rdata1 <= 32'd0;
        end else if (state == ACCESS) begin
            if (win) rdata1 <= (lat_we || lat_err) ? 32'd0 : mem_rdata;
            else     rdata0 <= (lat_we || lat_err) ? 32'd0 : mem_rdata;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Record the granted port in every RESP, error responses included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                last_grant <= 1'b1;
        else if (state == RESP) last_grant <= win;
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a scoreboard queue and
// a behavioural 64-word memory attached to the mem_* pins.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        ack0, err0, ack1, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          port;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_mem[64];   // expected memory contents
    logic [31:0] mem[64];       // memory attached to the DUT
    logic        preload;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .err0(err0), .rdata0(rdata0),
        .ack1(ack1), .err1(err1), .rdata1(rdata1),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: asynchronous read, write committed on the rising edge.
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        end else if (mem_write) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the acknowledged response.
    task automatic pop_compare(input string tag);
        exp_t e;
        bit   p;
        p = ack1;
        check({tag, "_ack_excl"}, {31'd0, ack0 & ack1}, 32'd0);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_port"},  {31'd0, p}, {31'd0, e.port});
            check({tag, "_err"},   {31'd0, p ? err1 : err0}, {31'd0, e.err});
            check({tag, "_rdata"}, p ? rdata1 : rdata0, e.rdata);
        end
    endtask

    task automatic drive_port(input bit port, input bit req, input bit we,
                              input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin req1 = req; we1 = we; addr1 = addr; wdata1 = wdata; end
        else      begin req0 = req; we0 = we; addr0 = addr; wdata0 = wdata; end
    endtask

    // One complete transaction on one port, with latency and pin-activity checks.
    task automatic do_txn(input string tag, input bit port, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bit          err;
        bit          seen;
        int          wr_cyc;
        int          rd_cyc;
        int          lat;
        logic [31:0] exp_rd;
        err    = (addr < 32'd1024) || (addr >= 32'd1280) || (addr[1:0] != 2'b00);
        exp_rd = 32'd0;
        if (!err) begin
            if (we) exp_mem[(addr - 32'd1024) >> 2] = wdata;
            else    exp_rd = exp_mem[(addr - 32'd1024) >> 2];
        end
        sb.push_back('{port: port, err: err, rdata: exp_rd});
        @(negedge clk);
        drive_port(port, 1'b1, we, addr, wdata);
        seen = 1'b0; wr_cyc = 0; rd_cyc = 0; lat = 0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clk);
            if (mem_write) wr_cyc++;
            if (mem_read)  rd_cyc++;
            if (mem_write || mem_read) check({tag, "_mem_addr"}, mem_addr, addr);
            if (ack0 || ack1) begin
                seen = 1'b1;
                lat  = c;
                drive_port(port, 1'b0, 1'b0, 32'd0, 32'd0);
                pop_compare(tag);
            end
        end
        if (!seen) begin
            check({tag, "_ack_timeout"}, 32'd0, 32'd1);
            drive_port(port, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        check({tag, "_latency"}, 32'(lat), 32'd2);
        check({tag, "_wr_cycles"}, 32'(wr_cyc), {31'd0, we & ~err});
        check({tag, "_rd_cycles"}, 32'(rd_cyc), {31'd0, ~we & ~err});
    endtask

    initial begin
        int n_ack;
        int last_c;
        int gap;
        int stray;
        rst = 1'b1; preload = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        for (int i = 0; i < 64; i++) exp_mem[i] = 32'hA500_0000 | 32'(i);
        repeat (2) @(negedge clk);
        preload = 1'b0;

        // Reset state.
        check("rst_ack0", {31'd0, ack0}, 32'd0);
        check("rst_ack1", {31'd0, ack1}, 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        check("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        // Single write then read on port 0.
        do_txn("wr1028", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        do_txn("rd1028", 1'b0, 1'b0, 32'd1028, 32'd0);

        // Out-of-range and misaligned addresses on port 1.
        do_txn("err1280", 1'b1, 1'b0, 32'd1280, 32'd0);
        do_txn("err1020", 1'b1, 1'b0, 32'd1020, 32'd0);
        do_txn("err1030", 1'b1, 1'b0, 32'd1030, 32'd0);
        check("rdata0_hold", rdata0, 32'hDEADBEEF);

        // First and last word of the memory.
        do_txn("wr1024", 1'b0, 1'b1, 32'd1024, 32'h00000001);
        do_txn("wr1276", 1'b1, 1'b1, 32'd1276, 32'hFFFFFFFF);
        do_txn("rd1024", 1'b1, 1'b0, 32'd1024, 32'd0);
        do_txn("rd1276", 1'b0, 1'b0, 32'd1276, 32'd0);

        // Reset during the ACCESS cycle of a write to 1032.
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b1, 32'd1032, 32'h12345678);
        @(negedge clk);
        check("abort_mem_write_before", {31'd0, mem_write}, 32'd1);
        #1 rst = 1'b1;
        drive_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("abort_mem_write", {31'd0, mem_write}, 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        check("abort_acks", {30'd0, ack0, ack1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack0 || ack1 || mem_read || mem_write) stray++;
        end
        check("abort_quiet", 32'(stray), 32'd0);
        do_txn("rd1032", 1'b0, 1'b0, 32'd1032, 32'd0);

        // Both ports requesting continuously, starting from a fresh reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        sb.push_back('{port: 1'b0, err: 1'b0, rdata: exp_mem[0]});
        sb.push_back('{port: 1'b1, err: 1'b0, rdata: exp_mem[63]});
        sb.push_back('{port: 1'b0, err: 1'b0, rdata: exp_mem[0]});
        sb.push_back('{port: 1'b1, err: 1'b0, rdata: exp_mem[63]});
`else
        repeat (4) sb.push_back('{port: 1'b0, err: 1'b0, rdata: exp_mem[0]});
`endif
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b0, 32'd1024, 32'd0);
        drive_port(1'b1, 1'b1, 1'b0, 32'd1276, 32'd0);
        n_ack = 0; last_c = 0;
        for (int c = 1; c <= 20 && n_ack < 4; c++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                n_ack++;
                gap    = c - last_c;
                last_c = c;
                check("tie_spacing", 32'(gap), (n_ack == 1) ? 32'd2 : 32'd3);
                pop_compare("tie");
                if (n_ack == 4) begin
                    drive_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
                    drive_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
                end
            end
        end
        drive_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        check("tie_ack_count", 32'(n_ack), 32'd4);
        check("sb_drained", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
